// File: rtl/ap_seq_pkg.sv
// Shared types and pass tables for the bit-serial add/sub sequencer.
package ap_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        CMP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int PASS_NUM = 4;

    typedef struct packed {
        logic [2:0] key;  // {A,B,C}
        logic [1:0] val;  // {B,C}
    } pass_t;

    // Execution order matters: a row rewritten by one pass must not match a later key.
    localparam pass_t [0:PASS_NUM-1] ADD_TABLE = '{
        '{key: 3'b110, val: 2'b01},
        '{key: 3'b100, val: 2'b10},
        '{key: 3'b001, val: 2'b10},
        '{key: 3'b011, val: 2'b01}
    };

    localparam pass_t [0:PASS_NUM-1] SUB_TABLE = '{
        '{key: 3'b011, val: 2'b00},
        '{key: 3'b001, val: 2'b11},
        '{key: 3'b100, val: 2'b11},
        '{key: 3'b110, val: 2'b00}
    };

endpackage

// File: rtl/ap_pass_rom.sv
// Combinational pass-table lookup: (op, pass) -> compare key and write value.
module ap_pass_rom
    import ap_seq_pkg::*;
(
    input  logic       op,
    input  logic [1:0] pass,
    output pass_t      entry
);

    always_comb begin
        entry = (op == OP_SUB) ? SUB_TABLE[pass] : ADD_TABLE[pass];
    end

endmodule

// File: rtl/ap_arith_seq.sv
// Bit-serial ADD/SUB compare/write sequencer for the associative array.
// Optional AP_SEQ_PERF_EN adds a saturating completed-operation counter (op_count).
module ap_arith_seq
    import ap_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx,
    output logic             cmp_en,
    output logic [2:0]       cmp_key,
    output logic             wr_en,
    output logic             wr_all,
    output logic [1:0]       wr_val
`ifdef AP_SEQ_PERF_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       LAST_PASS = 2'(PASS_NUM - 1);

    state_t           state_q, state_d;
    logic [1:0]       pass_q, pass_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             op_q, op_d;
    pass_t            entry_d;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                pass_d = 2'd0;
                idx_d  = '0;
                if (start) begin
                    state_d = CLR;
                    op_d    = op;
                end
            end
            CLR:  state_d = abort ? IDLE : CMP;
            CMP:  state_d = abort ? IDLE : WR;
            WR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pass_q != LAST_PASS) begin
                    pass_d  = pass_q + 2'd1;
                    state_d = CMP;
                end else if (idx_q != LAST_IDX) begin
                    pass_d  = 2'd0;
                    idx_d   = idx_q + 1'b1;
                    state_d = CMP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Look up the next pass so the outputs can be registered alongside the state.
    ap_pass_rom u_rom (
        .op   (op_d),
        .pass (pass_d),
        .entry(entry_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= 2'd0;
            idx_q   <= '0;
            op_q    <= OP_ADD;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
            cmp_en  <= 1'b0;
            cmp_key <= 3'b000;
            wr_en   <= 1'b0;
            wr_all  <= 1'b0;
            wr_val  <= 2'b00;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            busy    <= (state_d == CLR) || (state_d == CMP) || (state_d == WR);
            done    <= (state_d == DONE);
            bit_idx <= ((state_d == CMP) || (state_d == WR)) ? idx_d : '0;
            cmp_en  <= (state_d == CMP);
            cmp_key <= (state_d == CMP) ? entry_d.key : 3'b000;
            wr_en   <= (state_d == CLR) || (state_d == WR);
            wr_all  <= (state_d == CLR);
            wr_val  <= (state_d == WR) ? entry_d.val : 2'b00;
        end
    end

`ifdef AP_SEQ_PERF_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= 16'h0000;
        end else if ((state_d == DONE) && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'h0001;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_ap_arith_seq.sv
// Directed bench for ap_arith_seq, with a small associative-array model driven by its commands.
module tb_ap_arith_seq;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op;
    logic          abort;
    logic          busy;
    logic          done;
    logic [IW-1:0] bit_idx;
    logic          cmp_en;
    logic [2:0]    cmp_key;
    logic          wr_en;
    logic          wr_all;
    logic [1:0]    wr_val;
`ifdef AP_SEQ_PERF_EN
    logic [15:0]   op_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] a_m [NR];
    logic [DW-1:0] b_m [NR];
    logic          c_m [NR];
    logic          tag_m [NR];

    ap_arith_seq #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .bit_idx(bit_idx),
        .cmp_en (cmp_en),
        .cmp_key(cmp_key),
        .wr_en  (wr_en),
        .wr_all (wr_all),
        .wr_val (wr_val)
`ifdef AP_SEQ_PERF_EN
        ,
        .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] outs();
        return {busy, done, bit_idx, cmp_en, cmp_key, wr_en, wr_all, wr_val};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op: start is high during cycle 0; returns at cycle 1.
    task automatic start_op(input logic o);
        start = 1'b1;
        op    = o;
        tick();
        start = 1'b0;
    endtask

    // Apply the array-side effect of the commands visible in this cycle.
    task automatic step_model();
        if (cmp_en) begin
            for (int r = 0; r < NR; r++)
                tag_m[r] = ({a_m[r][bit_idx], b_m[r][bit_idx], c_m[r]} == cmp_key);
        end
        if (wr_en) begin
            for (int r = 0; r < NR; r++) begin
                if (wr_all) c_m[r] = wr_val[0];
                else if (tag_m[r]) {b_m[r][bit_idx], c_m[r]} = wr_val;
            end
        end
    endtask

    task automatic load_rows(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                             input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        a_m[0] = a0; b_m[0] = b0;
        a_m[1] = a1; b_m[1] = b1;
        a_m[2] = 16'h1234; b_m[2] = 16'h0F0F;
        a_m[3] = 16'h0000; b_m[3] = 16'h8000;
        for (int r = 0; r < NR; r++) begin
            c_m[r]   = 1'b1;
            tag_m[r] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0;
        #2;
        checks++;
        if (outs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_async outs=%h exp=0", outs());
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (outs() !== 14'h0) begin
                errors++;
                $display("FAIL idle_outs cyc=%0d outs=%h exp=0", i, outs());
            end
        end
    endtask

    task automatic test_add();
        int done_cyc;
        load_rows(16'd3, 16'd5, 16'hFFFF, 16'd1);
        done_cyc = -1;
        start_op(1'b0);
        checks++;
        if ({busy, wr_en, wr_all, wr_val, cmp_en} !== 6'b111000) begin
            errors++;
            $display("FAIL add_clr busy,wr_en,wr_all,wr_val,cmp_en=%b exp=111000",
                     {busy, wr_en, wr_all, wr_val, cmp_en});
        end
        for (int cyc = 1; cyc <= 131; cyc++) begin
            step_model();
            if (cyc == 2) begin
                checks++;
                if ({cmp_en, cmp_key, bit_idx, wr_en} !== {1'b1, 3'b110, 4'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL add_cmp0 cmp_en=%b key=%b idx=%0d exp 1/110/0", cmp_en, cmp_key, bit_idx);
                end
            end
            if (cyc == 3) begin
                checks++;
                if ({wr_en, wr_all, wr_val, cmp_en} !== 5'b10010) begin
                    errors++;
                    $display("FAIL add_wr0 wr_en,wr_all,wr_val,cmp_en=%b exp=10010",
                             {wr_en, wr_all, wr_val, cmp_en});
                end
            end
            if (cyc == 9) begin
                checks++;
                if ({wr_en, bit_idx, wr_val} !== {1'b1, 4'd0, 2'b01}) begin
                    errors++;
                    $display("FAIL add_bit0_last wr_en=%b idx=%0d val=%b exp 1/0/01", wr_en, bit_idx, wr_val);
                end
            end
            if (cyc == 10) begin
                checks++;
                if ({cmp_en, bit_idx, cmp_key} !== {1'b1, 4'd1, 3'b110}) begin
                    errors++;
                    $display("FAIL add_bit1 cmp_en=%b idx=%0d key=%b exp 1/1/110", cmp_en, bit_idx, cmp_key);
                end
            end
            if (cyc == 129) begin
                checks++;
                if ({busy, wr_en, bit_idx} !== {1'b1, 1'b1, 4'd15}) begin
                    errors++;
                    $display("FAIL add_last_wr busy=%b wr_en=%b idx=%0d exp 1/1/15", busy, wr_en, bit_idx);
                end
            end
            if (cyc == 130) begin
                checks++;
                if (outs() !== 14'h1000) begin
                    errors++;
                    $display("FAIL add_done outs=%h exp=1000", outs());
                end
            end
            if (cyc == 131) begin
                checks++;
                if (outs() !== 14'h0) begin
                    errors++;
                    $display("FAIL add_after_done outs=%h exp=0", outs());
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc < 131) tick();
        end
        checks++;
        if (done_cyc !== 130) begin
            errors++;
            $display("FAIL add_done_cycle got=%0d exp=130", done_cyc);
        end
        checks++;
        if ({b_m[0], b_m[1]} !== {16'd8, 16'd0}) begin
            errors++;
            $display("FAIL add_result b0=%h b1=%h exp 0008/0000", b_m[0], b_m[1]);
        end
        checks++;
        if ({b_m[2], b_m[3]} !== {16'h2143, 16'h8000}) begin
            errors++;
            $display("FAIL add_result_hi b2=%h b3=%h exp 2143/8000", b_m[2], b_m[3]);
        end
    endtask

    task automatic test_sub();
        logic [2:0] exp_key [4];
        logic [1:0] exp_val [4];
        int ncmp;
        int nwr;
        int guard;
        exp_key = '{3'b011, 3'b001, 3'b100, 3'b110};
        exp_val = '{2'b00, 2'b11, 2'b11, 2'b00};
        ncmp = 0; nwr = 0; guard = 0;
        load_rows(16'd3, 16'd5, 16'd1, 16'd0);
        start_op(1'b1);
        while (!done && guard < 200) begin
            step_model();
            if (cmp_en) begin
                checks++;
                if (cmp_key !== exp_key[ncmp % 4]) begin
                    errors++;
                    $display("FAIL sub_key n=%0d got=%b exp=%b", ncmp, cmp_key, exp_key[ncmp % 4]);
                end
                ncmp++;
            end
            if (wr_en && !wr_all) begin
                checks++;
                if (wr_val !== exp_val[nwr % 4]) begin
                    errors++;
                    $display("FAIL sub_val n=%0d got=%b exp=%b", nwr, wr_val, exp_val[nwr % 4]);
                end
                nwr++;
            end
            tick();
            guard++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL sub_timeout done=%b exp=1", done);
        end
        checks++;
        if (ncmp !== 64) begin
            errors++;
            $display("FAIL sub_cmp_count got=%0d exp=64", ncmp);
        end
        checks++;
        if ({b_m[0], b_m[1]} !== {16'd2, 16'hFFFF}) begin
            errors++;
            $display("FAIL sub_result b0=%h b1=%h exp 0002/ffff", b_m[0], b_m[1]);
        end
        checks++;
        if ({b_m[2], b_m[3]} !== {16'hFCDB, 16'h8000}) begin
            errors++;
            $display("FAIL sub_result_hi b2=%h b3=%h exp fcdb/8000", b_m[2], b_m[3]);
        end
        tick();
    endtask

    task automatic test_abort();
        int done_cnt;
        int done_cyc;
        start_op(1'b0);
        repeat (40) tick();
        // cycle 41: final WR of bit 4
        checks++;
        if ({wr_en, wr_all, bit_idx} !== {1'b1, 1'b0, 4'd4}) begin
            errors++;
            $display("FAIL abort_pre wr_en=%b wr_all=%b idx=%0d exp 1/0/4", wr_en, wr_all, bit_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (outs() !== 14'h0) begin
            errors++;
            $display("FAIL abort_idle outs=%h exp=0", outs());
        end
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d exp=0", done_cnt);
        end
        // abort while idle must not stop the new start
        abort = 1'b1;
        start_op(1'b0);
        abort = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 140 && done_cyc < 0; cyc++) begin
            if (done) done_cyc = cyc;
            else tick();
        end
        checks++;
        if (done_cyc !== 130) begin
            errors++;
            $display("FAIL abort_restart_done got=%0d exp=130", done_cyc);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        done_cnt = 0;
        start_op(1'b0);
        for (int cyc = 1; cyc <= 140; cyc++) begin
            if (done) done_cnt++;
            if (cyc == 131) begin
                checks++;
                if (outs() !== 14'h0) begin
                    errors++;
                    $display("FAIL start_in_done_ignored outs=%h exp=0", outs());
                end
            end
            start = (cyc == 10) || (cyc == 130);
            tick();
            start = 1'b0;
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL single_done got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        start_op(1'b1);
        repeat (19) tick();
        checks++;
        if ({cmp_en, busy} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre cmp_en=%b busy=%b exp 1/1", cmp_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 14'h0) begin
            errors++;
            $display("FAIL rst_mid_async outs=%h exp=0", outs());
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (outs() !== 14'h0) begin
            errors++;
            $display("FAIL rst_mid_after outs=%h exp=0", outs());
        end
    endtask

`ifdef AP_SEQ_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            start_op(1'b0);
            if (n == 2) begin
                repeat (20) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else begin
                repeat (130) tick();
            end
        end
        checks++;
        if (op_count !== 16'd3) begin
            errors++;
            $display("FAIL perf_count got=%0d exp=3", op_count);
        end
        force dut.op_count_q = 16'hFFFF;
        tick();
        release dut.op_count_q;
        start_op(1'b1);
        repeat (131) tick();
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate got=%h exp=ffff", op_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_abort();
        test_ignore_start();
        test_reset_mid();
`ifdef AP_SEQ_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
